// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer
//
// Streams host words into the chip's memories ahead of a compute phase. A load
// begins with a load_start pulse in IDLE. The first N_MAIN_WORDS accepted words
// go to the input/kernel memory (int_mem_we). The next N_OVERLAP_WORDS go to the
// overlap cache (overlap_cache_we). The sequencer then sits in READY with
// data_ready high until the chip reports fsm_done.
//
// Ports
//   clk              rising-edge clock
//   rst_in           synchronous active-high reset
//   load_start       one-cycle pulse, honoured only in IDLE
//   host_addr        host word address (bit 15 selects kernel vs input downstream)
//   host_data        host word data
//   host_valid       host presents a word
//   host_ready       sequencer accepts words (LOAD_MAIN / LOAD_OVL)
//   mem_addr         registered write address to the chip
//   mem_din          registered write data to the chip
//   int_mem_we       input/kernel memory write strobe, one cycle after accept
//   overlap_cache_we overlap cache write strobe, one cycle after accept
//   data_ready       all memories loaded (registered, high while in READY)
//   fsm_done         chip finished the loaded tile, honoured only in READY
//   busy             sequencer is not idle
//   addr_err         sticky: an overlap word had an out-of-range address

module mem_load_sequencer #(
  parameter int unsigned IO_DATA_WIDTH   = 16,
  parameter int unsigned N_MAIN_WORDS    = 16896,
  parameter int unsigned N_OVERLAP_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     load_start,
  input  logic [IO_DATA_WIDTH-1:0] host_addr,
  input  logic [IO_DATA_WIDTH-1:0] host_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [IO_DATA_WIDTH-1:0] mem_addr,
  output logic [IO_DATA_WIDTH-1:0] mem_din,
  output logic                     int_mem_we,
  output logic                     overlap_cache_we,
  output logic                     data_ready,
  input  logic                     fsm_done,
  output logic                     busy,
  output logic                     addr_err
);

  localparam int unsigned MaxWords = (N_MAIN_WORDS > N_OVERLAP_WORDS) ? N_MAIN_WORDS
                                                                      : N_OVERLAP_WORDS;
  localparam int unsigned CntW     = $clog2(MaxWords + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoadMain,
    StLoadOvl,
    StReady
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] word_cnt_q;

  logic accept;
  logic main_last;
  logic ovl_last;
  logic ovl_in_range;

  // host_ready is a pure decode of the state register so the host sees it
  // for the whole of both load phases, including stall cycles.
  assign host_ready = (state_q == StLoadMain) || (state_q == StLoadOvl);
  assign busy       = (state_q != StIdle);
  assign accept     = host_valid && host_ready;

  // Phase ends on the accept of the last word, so the counter never reaches N.
  assign main_last    = (word_cnt_q == CntW'(N_MAIN_WORDS - 1));
  assign ovl_last     = (word_cnt_q == CntW'(N_OVERLAP_WORDS - 1));
  assign ovl_in_range = (32'(host_addr) < N_OVERLAP_WORDS);

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q          <= StIdle;
      word_cnt_q       <= '0;
      mem_addr         <= '0;
      mem_din          <= '0;
      int_mem_we       <= 1'b0;
      overlap_cache_we <= 1'b0;
      data_ready       <= 1'b0;
      addr_err         <= 1'b0;
    end else begin
      // Strobes are single-cycle: only an accept on this edge raises one.
      int_mem_we       <= 1'b0;
      overlap_cache_we <= 1'b0;

      // Address/data bus only moves on an accept; otherwise it holds.
      if (accept) begin
        mem_addr <= host_addr;
        mem_din  <= host_data;
      end

      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q    <= StLoadMain;
            word_cnt_q <= '0;
            addr_err   <= 1'b0;
          end
        end

        StLoadMain: begin
          if (accept) begin
            // No address filtering here: kernel/input decode happens downstream.
            int_mem_we <= 1'b1;
            if (main_last) begin
              state_q    <= StLoadOvl;
              word_cnt_q <= '0;
            end else begin
              word_cnt_q <= word_cnt_q + CntW'(1);
            end
          end
        end

        StLoadOvl: begin
          if (accept) begin
            // Out-of-range words still count toward the phase but are dropped.
            if (ovl_in_range) begin
              overlap_cache_we <= 1'b1;
            end else begin
              addr_err <= 1'b1;
            end
            if (ovl_last) begin
              // data_ready rises together with the final overlap strobe.
              state_q    <= StReady;
              word_cnt_q <= '0;
              data_ready <= 1'b1;
            end else begin
              word_cnt_q <= word_cnt_q + CntW'(1);
            end
          end
        end

        StReady: begin
          if (fsm_done) begin
            state_q    <= StIdle;
            data_ready <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst_in)
    !(int_mem_we && overlap_cache_we));

  a_ready_matches_state: assert property (@(posedge clk) disable iff (rst_in)
    data_ready == (state_q == StReady));

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Scoreboard bench for mem_load_sequencer (N_MAIN_WORDS=4, N_OVERLAP_WORDS=2).
// The driver pushes each expected write (strobe kind, addr, data, cycle) as it
// issues the word; a negedge monitor pops one entry per observed strobe.

module tb_mem_load_sequencer;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_in;
  logic         load_start;
  logic [W-1:0] host_addr;
  logic [W-1:0] host_data;
  logic         host_valid;
  logic         host_ready;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_din;
  logic         int_mem_we;
  logic         overlap_cache_we;
  logic         data_ready;
  logic         fsm_done;
  logic         busy;
  logic         addr_err;

  mem_load_sequencer #(
    .IO_DATA_WIDTH  (W),
    .N_MAIN_WORDS   (4),
    .N_OVERLAP_WORDS(2)
  ) dut (
    .clk             (clk),
    .rst_in          (rst_in),
    .load_start      (load_start),
    .host_addr       (host_addr),
    .host_data       (host_data),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .int_mem_we      (int_mem_we),
    .overlap_cache_we(overlap_cache_we),
    .data_ready      (data_ready),
    .fsm_done        (fsm_done),
    .busy            (busy),
    .addr_err        (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;  // 0 = int_mem_we, 1 = overlap_cache_we
    logic [15:0] a;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (int_mem_we || overlap_cache_we) begin
      if (int_mem_we && overlap_cache_we) chk("strobe_exclusive", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {mem_addr, mem_din}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", {31'd0, overlap_cache_we}, e.kind);
        chk("strobe_addr", {16'd0, mem_addr}, {16'd0, e.a});
        chk("strobe_data", {16'd0, mem_din}, {16'd0, e.d});
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  // kind 2 = word accepted but no strobe expected.
  task automatic send(input logic [15:0] a, input logic [15:0] d, input int kind);
    exp_t e;
    chk("host_ready_in_load", {31'd0, host_ready}, 32'd1);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    if (kind != 2) begin
      e.kind = kind;
      e.a    = a;
      e.d    = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    step();
  endtask

  task automatic gap();
    host_valid = 1'b0;
    host_addr  = 16'hDEAD;
    host_data  = 16'hBEEF;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_host_ready"}, {31'd0, host_ready}, 32'd0);
    chk({tag, "_int_we"}, {31'd0, int_mem_we}, 32'd0);
    chk({tag, "_ovl_we"}, {31'd0, overlap_cache_we}, 32'd0);
    chk({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_din"}, {16'd0, mem_din}, 32'd0);
  endtask

  task automatic send_main4();
    send(16'h0001, 16'hAAAA, 0);
    send(16'h8002, 16'hBBBB, 0);
    send(16'h0003, 16'hCCCC, 0);
    send(16'h8004, 16'hDDDD, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in     = 1'b1;
    load_start = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    host_valid = 1'b0;
    fsm_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    check_reset_outputs("reset");

    // Basic back-to-back load.
    pulse_start();
    chk("basic_busy", {31'd0, busy}, 32'd1);
    send_main4();
    chk("basic_ready_after_main", {31'd0, data_ready}, 32'd0);
    send(16'h0000, 16'h1111, 1);
    chk("basic_ready_after_ovl1", {31'd0, data_ready}, 32'd0);
    send(16'h0001, 16'h2222, 1);
    host_valid = 1'b0;
    chk("basic_ready_with_last", {31'd0, data_ready}, 32'd1);
    chk("basic_last_ovl_we", {31'd0, overlap_cache_we}, 32'd1);
    chk("basic_host_ready_ready", {31'd0, host_ready}, 32'd0);
    chk("basic_addr_err", {31'd0, addr_err}, 32'd0);

    // Handover: load_start ignored in READY, fsm_done returns to IDLE.
    pulse_start();
    chk("handover_start_ignored", {31'd0, data_ready}, 32'd1);
    chk("handover_host_ready", {31'd0, host_ready}, 32'd0);
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
    chk("handover_data_ready", {31'd0, data_ready}, 32'd0);
    chk("handover_busy", {31'd0, busy}, 32'd0);

    // fsm_done ignored in IDLE.
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
    chk("idle_fsm_done_busy", {31'd0, busy}, 32'd0);

    // Stalls: valid toggles every cycle; bus must hold across gaps.
    pulse_start();
    send(16'h0001, 16'hAAAA, 0); gap();
    chk("stall_hold_addr", {16'd0, mem_addr}, 32'h0001);
    chk("stall_hold_din", {16'd0, mem_din}, 32'hAAAA);
    send(16'h8002, 16'hBBBB, 0); gap();
    send(16'h0003, 16'hCCCC, 0); gap();
    send(16'h8004, 16'hDDDD, 0); gap();
    send(16'h0000, 16'h1111, 1); gap();
    chk("stall_ready_mid_ovl", {31'd0, data_ready}, 32'd0);
    send(16'h0001, 16'h2222, 1);
    host_valid = 1'b0;
    chk("stall_data_ready", {31'd0, data_ready}, 32'd1);
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;

    // Overlap range check: addr 5 is counted but not written.
    pulse_start();
    send_main4();
    send(16'h0001, 16'h3333, 1);
    send(16'h0005, 16'h4444, 2);
    host_valid = 1'b0;
    chk("range_data_ready", {31'd0, data_ready}, 32'd1);
    chk("range_addr_err", {31'd0, addr_err}, 32'd1);
    chk("range_no_ovl_we", {31'd0, overlap_cache_we}, 32'd0);
    fsm_done = 1'b1;
    step();
    fsm_done = 1'b0;
    chk("range_err_sticky_idle", {31'd0, addr_err}, 32'd1);
    pulse_start();
    chk("range_err_cleared", {31'd0, addr_err}, 32'd0);

    // Mid-load reset after 2 words, then a full reload from word 0.
    send(16'h0001, 16'hAAAA, 0);
    send(16'h8002, 16'hBBBB, 0);
    host_valid = 1'b0;
    rst_in     = 1'b1;
    step();
    rst_in = 1'b0;
    check_reset_outputs("midreset");
    step();
    chk("midreset_no_strobe_q", exp_q.size(), 32'd0);
    pulse_start();
    send_main4();
    send(16'h0000, 16'h5555, 1);
    chk("reload_not_ready_5", {31'd0, data_ready}, 32'd0);
    send(16'h0001, 16'h6666, 1);
    host_valid = 1'b0;
    chk("reload_ready_6", {31'd0, data_ready}, 32'd1);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_load_sequencer.md
MEM_LOAD_SEQUENCER -- requirements
Module: mem_load_sequencer

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16: width of the host address and data words.
REQ-002 SHALL have parameter N_MAIN_WORDS, default 16896: input plus kernel words per load (16384 + 512).
REQ-003 SHALL have parameter N_OVERLAP_WORDS, default 256: overlap-cache words per load.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- load_start  in  1  one-cycle pulse that begins a load.
- host_addr  in  IO_DATA_WIDTH  word address; bit 15 = 1 selects kernel, 0 selects input.
- host_data  in  IO_DATA_WIDTH  word data.
- host_valid  in  1  host word valid.
- host_ready  out  1  sequencer accepts a word.
- mem_addr  out  IO_DATA_WIDTH  registered address to the chip write address bus (a_input).
- mem_din  out  IO_DATA_WIDTH  registered data to the chip write data bus (b_input).
- int_mem_we  out  1  input/kernel memory write strobe.
- overlap_cache_we  out  1  overlap cache write strobe.
- data_ready  out  1  all memories loaded; the chip may compute.
- fsm_done  in  1  chip finished computing the loaded tile.
- busy  out  1  a load or compute phase is active (state != IDLE).
- addr_err  out  1  sticky: an overlap address was out of range.

Function
REQ-005 SHALL implement the states IDLE, LOAD_MAIN, LOAD_OVL and READY.
REQ-006 IDLE -> LOAD_MAIN on load_start; load_start SHALL be ignored in any other state.
REQ-007 LOAD_MAIN -> LOAD_OVL on the cycle the N_MAIN_WORDS-th word is accepted.
REQ-008 LOAD_OVL -> READY on the cycle the N_OVERLAP_WORDS-th word is accepted.
REQ-009 READY -> IDLE on fsm_done; fsm_done SHALL be ignored outside READY.
REQ-010 host_ready SHALL be 1 exactly in LOAD_MAIN and LOAD_OVL, combinationally from state.
REQ-011 A word SHALL be accepted on a cycle with host_valid && host_ready; host_data and host_addr SHALL NOT be sampled otherwise.
REQ-012 On an accept, mem_addr and mem_din SHALL register host_addr and host_data; the matching strobe SHALL be 1 on the next cycle only (latency 1).
- In LOAD_MAIN the strobe is int_mem_we.
- In LOAD_OVL the strobe is overlap_cache_we.
REQ-013 int_mem_we and overlap_cache_we SHALL never be 1 together, and each SHALL be 0 on cycles following non-accept cycles.
REQ-014 mem_addr and mem_din SHALL hold their last values when no word is accepted.
REQ-015 A word counter of width $clog2(max(N_MAIN_WORDS, N_OVERLAP_WORDS)+1) SHALL count accepted words.
- It SHALL clear on entry to LOAD_MAIN and on entry to LOAD_OVL.
- It SHALL never wrap.
REQ-016 In LOAD_OVL, a word with host_addr >= N_OVERLAP_WORDS SHALL be accepted and counted but SHALL NOT be written.
- overlap_cache_we stays 0 for that word.
- addr_err is set and stays set until the next load_start accepted in IDLE, or reset.
REQ-017 host_addr bit 15 SHALL pass through unchanged in LOAD_MAIN; decode is performed downstream; the sequencer SHALL NOT filter LOAD_MAIN addresses.
REQ-018 data_ready SHALL be a registered output, 1 exactly while in READY.
REQ-019 The final LOAD_OVL write strobe SHALL occur on the same cycle data_ready first rises.
REQ-020 When host_valid is deasserted mid-load, the state and counter SHALL hold and no strobe SHALL be issued; there is no timeout.

Reset
REQ-021 rst_in SHALL take effect on the rising clk edge and override all other inputs.
REQ-022 On reset the state SHALL be IDLE and the counter 0.
REQ-023 After reset the outputs SHALL be: host_ready=0, int_mem_we=0, overlap_cache_we=0, data_ready=0, busy=0, addr_err=0, mem_addr=0, mem_din=0.
REQ-024 Reset asserted mid-load SHALL abandon the load with no further strobes; a subsequent load SHALL restart from word 0.

Verification (N_MAIN_WORDS=4, N_OVERLAP_WORDS=2)
REQ-025 Basic load: load_start, then 6 back-to-back words {0x0001/0xAAAA, 0x8002/0xBBBB, ...} -> 4 int_mem_we pulses, then 2 overlap_cache_we pulses, each one cycle after its accept, with matching mem_addr/mem_din; data_ready rises with the 6th strobe.
REQ-026 Stalls: host_valid toggled 1-0-1 every cycle -> the same 6 writes, no strobe on gap cycles, host_ready stays 1 throughout.
REQ-027 Overlap range check: overlap words with addr 0x0001 and 0x0005 -> one overlap_cache_we (addr 1), addr_err=1, data_ready=1 after both accepts.
REQ-028 Handover: in READY, pulse load_start (ignored), then pulse fsm_done -> IDLE, data_ready=0, busy=0; a new load_start clears addr_err.
REQ-029 Mid-load reset: rst_in asserted after 2 words -> all outputs at reset values the next cycle; a new load needs a full 6 words to reach READY.
